dac_serial_tx: RTL and testbench



---
 rtl/dac_serial_tx.sv | 146 ++++++++++++++
 tb/tb_dac_serial_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_serial_tx.sv
// Serial transmitter for a 12-bit SPI-style DAC: 16-bit frames, MSB first, divided sclk, active-low CS.
// Define DAC_PWRDN_EN to add the 2-bit power-down input i_pd, sent as frame bits 13:12.
module dac_serial_tx #(
  parameter int SCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] i_data_in,
`ifdef DAC_PWRDN_EN
  input  logic [1:0]  i_pd,
`endif
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_sclk,
  output logic        o_cs,
  output logic        o_sdata
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  localparam int            PW         = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(SCLK_DIV - 1);

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_phase, w_phase_nxt;
  logic          r_half, w_half_nxt;
  logic [3:0]    r_bit, w_bit_nxt;
  logic [15:0]   r_shift, w_shift_nxt;
  logic          r_ready, r_done, r_sclk, r_cs;
  logic          w_ready_nxt, w_done_nxt, w_sclk_nxt, w_cs_nxt;
  logic          w_accept, w_phase_end;
  logic [15:0]   w_frame;

`ifdef DAC_PWRDN_EN
  assign w_frame = {2'b00, i_pd, i_data_in};
`else
  assign w_frame = {4'b0000, i_data_in};
`endif

  // r_ready is high exactly in IDLE, so it doubles as the accept qualifier.
  assign w_accept    = i_valid & r_ready;
  assign w_phase_end = (r_phase == PHASE_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: each combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_phase_end && r_half && (r_bit == 4'd15)) w_state_nxt = S_GAP;
      S_GAP:   if (w_phase_end && r_half) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // r_half selects the first (sclk high) or second (sclk low) half of a bit or of the gap.
  always_comb begin
    w_phase_nxt = r_phase;
    w_half_nxt  = r_half;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    case (r_state)
      S_IDLE: begin
        w_phase_nxt = '0;
        w_half_nxt  = 1'b0;
        w_bit_nxt   = '0;
        if (w_accept) w_shift_nxt = w_frame;
      end
      S_SHIFT: begin
        if (w_phase_end) begin
          w_phase_nxt = '0;
          w_half_nxt  = ~r_half;
          if (r_half) begin
            if (r_bit == 4'd15) begin
              w_bit_nxt   = '0;
              w_shift_nxt = '0;
            end else begin
              w_bit_nxt   = r_bit + 4'd1;
              w_shift_nxt = {r_shift[14:0], 1'b0};
            end
          end
        end else begin
          w_phase_nxt = r_phase + PW'(1);
        end
      end
      S_GAP: begin
        if (w_phase_end) begin
          w_phase_nxt = '0;
          w_half_nxt  = ~r_half;
        end else begin
          w_phase_nxt = r_phase + PW'(1);
        end
      end
      default: begin
        w_phase_nxt = '0;
        w_half_nxt  = 1'b0;
        w_bit_nxt   = '0;
        w_shift_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from next-state values and then registered, keeping pins glitch-free.
  always_comb begin
    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_cs_nxt    = (w_state_nxt != S_SHIFT);
    w_sclk_nxt  = (w_state_nxt == S_SHIFT) ? ~w_half_nxt : 1'b1;
    w_done_nxt  = (r_state == S_SHIFT) && (w_state_nxt == S_GAP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= '0;
      r_half  <= 1'b0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_sclk  <= 1'b1;
      r_cs    <= 1'b1;
    end else begin
      r_phase <= w_phase_nxt;
      r_half  <= w_half_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
      r_sclk  <= w_sclk_nxt;
      r_cs    <= w_cs_nxt;
    end
  end

  // The shift register is cleared outside SHIFT, so its MSB is directly the idle-low data pin.
  assign o_ready = r_ready;
  assign o_done  = r_done;
  assign o_sclk  = r_sclk;
  assign o_cs    = r_cs;
  assign o_sdata = r_shift[15];

endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx at SCLK_DIV=4: records outputs per cycle after each accept and checks frame timing.
module tb_dac_serial_tx;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] data_in;
  logic        valid;
`ifdef DAC_PWRDN_EN
  logic [1:0]  pd;
`endif
  logic        ready, done, sclk, cs, sdata;

  int checks   = 0;
  int failures = 0;

  // Index k holds the outputs sampled on the k-th falling clk edge after the accept edge (k=0: just before it).
  logic cs_a    [0:299];
  logic sclk_a  [0:299];
  logic sdata_a [0:299];
  logic done_a  [0:299];
  logic ready_a [0:299];

  dac_serial_tx #(.SCLK_DIV(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_data_in (data_in),
`ifdef DAC_PWRDN_EN
    .i_pd      (pd),
`endif
    .i_valid   (valid),
    .o_ready   (ready),
    .o_done    (done),
    .o_sclk    (sclk),
    .o_cs      (cs),
    .o_sdata   (sdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int k);
    cs_a[k]    = cs;
    sclk_a[k]  = sclk;
    sdata_a[k] = sdata;
    done_a[k]  = done;
    ready_a[k] = ready;
  endtask

  // Records n cycles; stimulus indices of 0 mean "not used". Inputs change on falling edges.
  task automatic observe(input int n, input int valid_off_k, input int data_k,
                         input logic [11:0] data_v, input int pulse_k, input int reset_k);
    sample(0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      sample(k);
      if (k == valid_off_k) valid = 1'b0;
      if (k == data_k) data_in = data_v;
      if (k == pulse_k) begin
        valid   = 1'b1;
        data_in = data_v;
      end
      if (pulse_k != 0 && k == pulse_k + 1) valid = 1'b0;
      if (k == reset_k) reset = 1'b1;
      if (reset_k != 0 && k == reset_k + 1) reset = 1'b0;
    end
  endtask

  function automatic logic sig(input int sel, input int k);
    case (sel)
      0:       return cs_a[k];
      1:       return sclk_a[k];
      2:       return sdata_a[k];
      3:       return done_a[k];
      default: return ready_a[k];
    endcase
  endfunction

  function automatic int count_of(input int sel, input logic val, input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (sig(sel, k) === val) c++;
    return c;
  endfunction

  function automatic int first_of(input int sel, input logic val, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) if (sig(sel, k) === val) return k;
    return -1;
  endfunction

  // Shifts in sdata at each sclk falling edge and counts sdata changes within +/-D cycles of it.
  task automatic analyze(input int lo, input int hi, output logic [15:0] fr, output int nf,
                         output int ff, output int lf, output int bad);
    fr = '0; nf = 0; ff = -1; lf = -1; bad = 0;
    for (int k = lo; k <= hi; k++) begin
      if (k >= 1 && sclk_a[k-1] === 1'b1 && sclk_a[k] === 1'b0) begin
        fr = {fr[14:0], sdata_a[k]};
        nf++;
        if (ff < 0) ff = k;
        lf = k;
        for (int j = k - D; j <= k + D - 1; j++) if (sdata_a[j] !== sdata_a[k]) bad++;
      end
    end
  endtask

  logic [15:0] fr;
  logic [15:0] exp_pd_frame;
  int nf, ff, lf, bad;

  initial begin
    reset   = 1'b1;
    valid   = 1'b0;
    data_in = '0;
`ifdef DAC_PWRDN_EN
    pd      = 2'b00;
`endif

    // Reset held for three edges, then released.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_cs",    32'(cs),    32'd1);
    check("rst_sclk",  32'(sclk),  32'd1);
    check("rst_sdata", 32'(sdata), 32'd0);
    check("rst_done",  32'(done),  32'd0);

    // Single frame 12'hA5C; data_in changes right after the accept.
    data_in = 12'hA5C;
    valid   = 1'b1;
    observe(150, 1, 3, 12'h0F0, 0, 0);
    analyze(1, 150, fr, nf, ff, lf, bad);
    check("f1_frame",     32'(fr), 32'h0A5C);
    check("f1_falls",     nf, 16);
    check("f1_first_fall", ff, 5);
    check("f1_last_fall", lf, 125);
    check("f1_unstable",  bad, 0);
    check("f1_cs_first_low", first_of(0, 1'b0, 1, 150), 1);
    check("f1_cs_low_cnt",   count_of(0, 1'b0, 1, 150), 128);
    check("f1_cs_at_129",    32'(cs_a[129]), 32'd1);
    check("f1_done_at",      first_of(3, 1'b1, 1, 150), 129);
    check("f1_done_cnt",     count_of(3, 1'b1, 1, 150), 1);
    check("f1_ready_back",   first_of(4, 1'b1, 1, 150), 137);

    // Back-to-back with valid held: 12'hFFF, then 12'h001 waiting at the next ready.
    data_in = 12'hFFF;
    valid   = 1'b1;
    observe(290, 140, 100, 12'h001, 0, 0);
    analyze(1, 136, fr, nf, ff, lf, bad);
    check("b2b_frame1", 32'(fr), 32'h0FFF);
    check("b2b_falls1", nf, 16);
    analyze(137, 274, fr, nf, ff, lf, bad);
    check("b2b_frame2",      32'(fr), 32'h0001);
    check("b2b_first_fall2", ff, 142);
    check("b2b_unstable2",   bad, 0);
    check("b2b_cs_at_137",   32'(cs_a[137]), 32'd1);
    check("b2b_cs_fall2",    first_of(0, 1'b0, 130, 290), 138);
    check("b2b_done_cnt",    count_of(3, 1'b1, 1, 290), 2);
    check("b2b_cs_low_cnt",  count_of(0, 1'b0, 1, 290), 256);

    // Busy ignore: a valid pulse with 12'h123 mid-frame must not start or alter anything.
    data_in = 12'h5A3;
    valid   = 1'b1;
    observe(160, 1, 0, 12'h123, 50, 0);
    analyze(1, 160, fr, nf, ff, lf, bad);
    check("busy_frame",      32'(fr), 32'h05A3);
    check("busy_ready_51",   32'(ready_a[51]), 32'd0);
    check("busy_ready_back", first_of(4, 1'b1, 1, 160), 137);
    check("busy_done_cnt",   count_of(3, 1'b1, 1, 160), 1);
    check("busy_cs_low_cnt", count_of(0, 1'b0, 1, 160), 128);

    // Reset mid-frame, applied during an sclk-low phase.
    data_in = 12'h3C7;
    valid   = 1'b1;
    observe(150, 1, 0, 12'h000, 0, 62);
    check("mid_cs_62",    32'(cs_a[62]),    32'd0);
    check("mid_sclk_62",  32'(sclk_a[62]),  32'd0);
    check("mid_cs_63",    32'(cs_a[63]),    32'd1);
    check("mid_sclk_63",  32'(sclk_a[63]),  32'd1);
    check("mid_ready_63", 32'(ready_a[63]), 32'd1);
    check("mid_sdata_63", 32'(sdata_a[63]), 32'd0);
    check("mid_no_done",  count_of(3, 1'b1, 1, 150), 0);
    check("mid_cs_idle",  count_of(0, 1'b0, 63, 150), 0);

    // Clean frame after the abandoned one.
    data_in = 12'h3C7;
    valid   = 1'b1;
    observe(150, 1, 0, 12'h000, 0, 0);
    analyze(1, 150, fr, nf, ff, lf, bad);
    check("post_frame",    32'(fr), 32'h03C7);
    check("post_done_at",  first_of(3, 1'b1, 1, 150), 129);

    // Power-down bits: pd=11 with 12'h800.
`ifdef DAC_PWRDN_EN
    pd           = 2'b11;
    exp_pd_frame = 16'h3800;
`else
    exp_pd_frame = 16'h0800;
`endif
    data_in = 12'h800;
    valid   = 1'b1;
    observe(150, 1, 0, 12'h000, 0, 0);
    analyze(1, 150, fr, nf, ff, lf, bad);
    check("pd_frame", 32'(fr), 32'(exp_pd_frame));
    check("pd_falls", nf, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
